cs_check: RTL and testbench

CS_CHECK -- requirements
Module: cs_check

---
 rtl/cs_check.sv | 235 +++++++++++++++++++++++
 tb/tb_cs_check.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_check.sv
// cs_check: frame checksum verifier.
// Each frame is 17 beats of 32 bits: beats 0-11 form segment 1, beats 12-15
// form segment 2 and beat 16 carries the received checksums in its low half.
// Each segment checksum is the inverted 8-bit ones'-complement sum of all of
// its bytes. One verdict pulse is produced per completed frame. A frame that
// stalls for 100 consecutive idle cycles is aborted with a timeout verdict.
// Optional statistics counters are enabled by defining CS_CHECK_STAT_EN.

module cs_check (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] data,
  output logic        out_valid,
  output logic [15:0] result,
  output logic        match,
  output logic        timeout
`ifdef CS_CHECK_STAT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEG1 = 2'd1,
    SEG2 = 2'd2,
    CHK  = 2'd3
  } stateT;

  localparam logic [4:0] LAST_SEG1_BEAT = 5'd11;
  localparam logic [4:0] LAST_SEG2_BEAT = 5'd15;
  localparam logic [6:0] IDLE_LIMIT     = 7'd99;

  stateT       state_q,    state_d;
  logic [4:0]  beatCnt_q,  beatCnt_d;
  logic [6:0]  idleCnt_q,  idleCnt_d;
  logic [7:0]  acc1_q,     acc1_d;
  logic [7:0]  acc2_q,     acc2_d;
  logic        outValid_q, outValid_d;
  logic [15:0] result_q,   result_d;
  logic        match_q,    match_d;
  logic        timeout_q,  timeout_d;

  logic [7:0]  beatSum1;
  logic [7:0]  beatSum2;
  logic [7:0]  cs1;
  logic [7:0]  cs2;
  logic        inFrame;
  logic        idleExpire;
  logic        frameDone;
  logic        frameMatch;

  // Adds the four bytes of a beat into an 8-bit ones'-complement accumulator.
  // The 11-bit raw sum is folded twice: the first fold leaves at most 9 bits,
  // and when its carry is set the low byte is small enough that the second
  // fold can never carry again, so no end-around carry is ever lost.
  function automatic logic [7:0] foldBeat(input logic [7:0]  acc,
                                          input logic [31:0] beat);
    logic [10:0] wide;
    logic [8:0]  once;
    logic [7:0]  twice;
    wide  = {3'b000, acc}
          + {3'b000, beat[31:24]}
          + {3'b000, beat[23:16]}
          + {3'b000, beat[15:8]}
          + {3'b000, beat[7:0]};
    once  = {1'b0, wide[7:0]} + {6'b000000, wide[10:8]};
    twice = once[7:0] + {7'b0000000, once[8]};
    return twice;
  endfunction

  // Shared decode: candidate accumulator updates, final checksums, and the
  // two events that end a frame (a completed frame or an inactivity abort).
  always_comb begin
    beatSum1   = foldBeat(acc1_q, data);
    beatSum2   = foldBeat(acc2_q, data);
    cs1        = ~acc1_q;
    cs2        = ~acc2_q;
    inFrame    = (state_q != IDLE);
    idleExpire = inFrame && !in_valid && (idleCnt_q == IDLE_LIMIT);
    frameDone  = (state_q == CHK) && in_valid;
    frameMatch = (cs1 == data[15:8]) && (cs2 == data[7:0]);
  end

  // State and datapath registers; a low rst_n at the edge wins over any beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beatCnt_q  <= 5'd0;
      idleCnt_q  <= 7'd0;
      acc1_q     <= 8'h00;
      acc2_q     <= 8'h00;
      outValid_q <= 1'b0;
      result_q   <= 16'h0000;
      match_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beatCnt_q  <= beatCnt_d;
      idleCnt_q  <= idleCnt_d;
      acc1_q     <= acc1_d;
      acc2_q     <= acc2_d;
      outValid_q <= outValid_d;
      result_q   <= result_d;
      match_q    <= match_d;
      timeout_q  <= timeout_d;
    end
  end

  // Frame sequencing: segments advance only on accepted beats, and any
  // in-frame state falls back to IDLE once the inactivity limit is reached.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SEG1;
        end
      end
      SEG1: begin
        if (in_valid && (beatCnt_q == LAST_SEG1_BEAT)) begin
          state_d = SEG2;
        end else if (idleExpire) begin
          state_d = IDLE;
        end
      end
      SEG2: begin
        if (in_valid && (beatCnt_q == LAST_SEG2_BEAT)) begin
          state_d = CHK;
        end else if (idleExpire) begin
          state_d = IDLE;
        end
      end
      CHK: begin
        if (in_valid || idleExpire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulation, beat/idle counting and the one-cycle verdict; the verdict
  // fields default to zero so they are only non-zero alongside out_valid.
  always_comb begin
    beatCnt_d  = beatCnt_q;
    idleCnt_d  = idleCnt_q;
    acc1_d     = acc1_q;
    acc2_d     = acc2_q;
    outValid_d = 1'b0;
    result_d   = 16'h0000;
    match_d    = 1'b0;
    timeout_d  = 1'b0;

    if (!inFrame) begin
      idleCnt_d = 7'd0;
      if (in_valid) begin
        acc1_d    = beatSum1;
        beatCnt_d = 5'd1;
      end
    end else if (in_valid) begin
      idleCnt_d = 7'd0;
      unique case (state_q)
        SEG1: begin
          acc1_d    = beatSum1;
          beatCnt_d = beatCnt_q + 5'd1;
        end
        SEG2: begin
          acc2_d    = beatSum2;
          beatCnt_d = beatCnt_q + 5'd1;
        end
        default: begin
          outValid_d = 1'b1;
          result_d   = {cs1, cs2};
          match_d    = frameMatch;
          beatCnt_d  = 5'd0;
          acc1_d     = 8'h00;
          acc2_d     = 8'h00;
        end
      endcase
    end else if (idleExpire) begin
      outValid_d = 1'b1;
      timeout_d  = 1'b1;
      idleCnt_d  = 7'd0;
      beatCnt_d  = 5'd0;
      acc1_d     = 8'h00;
      acc2_d     = 8'h00;
    end else begin
      idleCnt_d = idleCnt_q + 7'd1;
    end
  end

  // Verdict outputs come straight from registers.
  always_comb begin
    out_valid = outValid_q;
    result    = result_q;
    match     = match_q;
    timeout   = timeout_q;
  end

`ifdef CS_CHECK_STAT_EN
  logic [15:0] frameCnt_q, frameCnt_d;
  logic [15:0] errCnt_q,   errCnt_d;

  // Saturating statistics: completed frames, and verdicts that are either a
  // checksum miss or an inactivity abort.
  always_comb begin
    frameCnt_d = frameCnt_q;
    errCnt_d   = errCnt_q;
    if (frameDone && (frameCnt_q != 16'hFFFF)) begin
      frameCnt_d = frameCnt_q + 16'd1;
    end
    if (((frameDone && !frameMatch) || idleExpire) && (errCnt_q != 16'hFFFF)) begin
      errCnt_d = errCnt_q + 16'd1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frameCnt_q <= 16'd0;
      errCnt_q   <= 16'd0;
    end else begin
      frameCnt_q <= frameCnt_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign frame_cnt = frameCnt_q;
  assign err_cnt   = errCnt_q;
`endif

endmodule

// File: tb/tb_cs_check.sv
// tb_cs_check: randomized and directed bench for cs_check with a frame-level
// reference model (beat list plus byte-wise ones'-complement arithmetic).

`timescale 1ns/1ps

module tb_cs_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] data = 32'h0;
  logic        out_valid;
  logic [15:0] result;
  logic        match;
  logic        timeout;
`ifdef CS_CHECK_STAT_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;
  int dutVerdicts = 0;
  int modelVerdicts = 0;

  // Reference model outputs for the current cycle.
  logic        mValid = 1'b0;
  logic [15:0] mResult = 16'h0;
  logic        mMatch = 1'b0;
  logic        mTimeout = 1'b0;
  int          mFrames = 0;
  int          mErrs = 0;

  logic [31:0] mFrame[17];
  int          mCount = 0;
  int          mIdle = 0;

  logic [31:0] frameW[17];

  // 10 ns clock.
  always #5 clk = ~clk;

  cs_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data      (data),
    .out_valid (out_valid),
    .result    (result),
    .match     (match),
    .timeout   (timeout)
`ifdef CS_CHECK_STAT_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  // Inverted ones'-complement byte sum over words first..last, one byte at a time.
  function automatic logic [7:0] segCks(input logic [31:0] w[17], input int first, input int last);
    int s;
    logic [7:0] r;
    s = 0;
    for (int i = first; i <= last; i++) begin
      for (int b = 0; b < 4; b++) begin
        s = s + int'(w[i][8*b +: 8]);
        if (s > 255) s = s - 255;
      end
    end
    r = s[7:0];
    return ~r;
  endfunction

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed verdict check at the current negedge, also pinning the model.
  task automatic checkOutput(input string name, input logic [15:0] expRes,
                             input logic expMatch, input logic expTo);
    compare({name, " out_valid"}, {15'b0, out_valid}, 16'd1);
    compare({name, " result"}, result, expRes);
    compare({name, " match"}, {15'b0, match}, {15'b0, expMatch});
    compare({name, " timeout"}, {15'b0, timeout}, {15'b0, expTo});
    compare({name, " model"}, mResult, expRes);
  endtask

  // Drives nBeats beats of w, with 0..maxGap idle cycles between beats.
  // Returns with the last beat still presented at the current negedge.
  task automatic applyStimulus(input logic [31:0] w[17], input int maxGap, input int nBeats = 17);
    int g;
    for (int i = 0; i < nBeats; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data     = w[i];
      if (i < nBeats - 1 && maxGap > 0) begin
        g = $urandom_range(maxGap, 0);
        repeat (g) begin
          @(negedge clk);
          in_valid = 1'b0;
          data     = $urandom;
        end
      end
    end
  endtask

  // Reference model: collect beats of the frame, verdict one cycle later.
  initial begin
    logic [7:0] c1;
    logic [7:0] c2;
    forever begin
      @(posedge clk);
      mValid   = 1'b0;
      mResult  = 16'h0;
      mMatch   = 1'b0;
      mTimeout = 1'b0;
      if (!rst_n) begin
        mCount = 0;
        mIdle  = 0;
      end else if (in_valid) begin
        mFrame[mCount] = data;
        mCount++;
        mIdle = 0;
        if (mCount == 17) begin
          c1      = segCks(mFrame, 0, 11);
          c2      = segCks(mFrame, 12, 15);
          mValid  = 1'b1;
          mResult = {c1, c2};
          mMatch  = (c1 == mFrame[16][15:8]) && (c2 == mFrame[16][7:0]);
          mCount  = 0;
          mFrames++;
          if (!mMatch) mErrs++;
        end
      end else if (mCount > 0) begin
        mIdle++;
        if (mIdle == 100) begin
          mValid   = 1'b1;
          mTimeout = 1'b1;
          mCount   = 0;
          mIdle    = 0;
          mErrs++;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        compare("cyc out_valid", {15'b0, out_valid}, {15'b0, mValid});
        compare("cyc result", result, mResult);
        compare("cyc match", {15'b0, match}, {15'b0, mMatch});
        compare("cyc timeout", {15'b0, timeout}, {15'b0, mTimeout});
        if (out_valid === 1'b1) dutVerdicts++;
        if (mValid) modelVerdicts++;
      end
    end
  end

  // Main sequence.
  initial begin
    int waited;
    logic [7:0] c1;
    logic [7:0] c2;

    $display("[TB] start");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    compare("reset out_valid", {15'b0, out_valid}, 16'd0);
    compare("reset result", result, 16'd0);
    compare("reset match", {15'b0, match}, 16'd0);
    compare("reset timeout", {15'b0, timeout}, 16'd0);
    rst_n = 1'b1;

    // All-zero frame.
    for (int i = 0; i < 16; i++) frameW[i] = 32'h0;
    frameW[16] = 32'h0000FFFF;
    applyStimulus(frameW, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("zero frame", 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    compare("pulse width", {15'b0, out_valid}, 16'd0);

    // Small counts frame, matching then mismatching.
    for (int i = 0; i < 12; i++) frameW[i] = 32'h01010101;
    for (int i = 12; i < 16; i++) frameW[i] = 32'h00000001;
    frameW[16] = 32'h0000CFFB;
    applyStimulus(frameW, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("ones frame", 16'hCFFB, 1'b1, 1'b0);
    frameW[16] = 32'h0000CFFA;
    applyStimulus(frameW, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bad cks", 16'hCFFB, 1'b0, 1'b0);

    // End-around carry frame.
    for (int i = 0; i < 16; i++) frameW[i] = 32'hFFFFFFFF;
    frameW[16] = 32'h00000000;
    applyStimulus(frameW, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("carry frame", 16'h0000, 1'b1, 1'b0);

    // Random frames with random gaps, optionally back-to-back.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) frameW[i] = $urandom;
      c1 = segCks(frameW, 0, 11);
      c2 = segCks(frameW, 12, 15);
      if (f % 2 == 0) frameW[16] = {16'($urandom), c1, c2};
      else frameW[16] = $urandom;
      applyStimulus(frameW, 2);
      if ($urandom_range(1, 0) == 1) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end

    // Two directed frames with zero gap.
    for (int i = 0; i < 12; i++) frameW[i] = 32'h01010101;
    for (int i = 12; i < 16; i++) frameW[i] = 32'h00000001;
    frameW[16] = 32'h0000CFFB;
    applyStimulus(frameW, 0);
    for (int i = 0; i < 16; i++) frameW[i] = 32'h0;
    frameW[16] = 32'h0000FFFF;
    applyStimulus(frameW, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("b2b second", 16'hFFFF, 1'b1, 1'b0);

    // Inactivity abort after beat 5, then a clean frame.
    applyStimulus(frameW, 0, 6);
    @(negedge clk);
    in_valid = 1'b0;
    waited = 201;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        waited = k;
        break;
      end
    end
    compare("timeout latency", 16'(waited), 16'd100);
    if (waited <= 200) checkOutput("timeout", 16'h0000, 1'b0, 1'b1);
    applyStimulus(frameW, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("after timeout", 16'hFFFF, 1'b1, 1'b0);

    // Reset mid-frame after beat 9, with in_valid high during reset.
    for (int i = 0; i < 12; i++) frameW[i] = 32'h01010101;
    for (int i = 12; i < 16; i++) frameW[i] = 32'h00000001;
    frameW[16] = 32'h0000CFFB;
    applyStimulus(frameW, 0, 10);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data     = $urandom;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    compare("midrst out_valid", {15'b0, out_valid}, 16'd0);
    compare("midrst result", result, 16'd0);
    repeat (3) @(negedge clk);
    applyStimulus(frameW, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("after reset", 16'hCFFB, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    compare("verdict count dut", 16'(dutVerdicts), 16'd15);
    compare("verdict count model", 16'(modelVerdicts), 16'd15);
`ifdef CS_CHECK_STAT_EN
    compare("frame_cnt", frame_cnt, 16'(mFrames));
    compare("err_cnt", err_cnt, 16'(mErrs));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
